// File: rtl/fwrisc_lsu_if.sv
// Core-request/response and data-bus signal bundle for the fwrisc load/store unit.
// The slave modport is the LSU view; master is the core-plus-memory environment.
interface fwrisc_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dstrb;
    logic        dwrite;
    logic        dvalid;
    logic        dready;
    logic [31:0] drdata;

    modport slave (
        input  req_valid, req_addr, req_write, req_size, req_unsigned, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault,
        output daddr, dwdata, dstrb, dwrite, dvalid,
        input  dready, drdata
    );

    modport master (
        output req_valid, req_addr, req_write, req_size, req_unsigned, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
        input  daddr, dwdata, dstrb, dwrite, dvalid,
        output dready, drdata
    );
endinterface

// File: rtl/fwrisc_lsu.sv
// fwrisc load/store unit: one outstanding access, byte strobes, lane replication,
// load extension, and misalignment/timeout faults back to the core.
module fwrisc_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic          clock,
    input logic          reset,
    fwrisc_lsu_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    localparam logic [7:0] TO_LAST = 8'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_t      state, state_n;
    logic [1:0]  lane_q, size_q;
    logic        uns_q, wr_q;
    logic [7:0]  cnt;
    logic        dvalid, dwrite, rsp_valid, rsp_fault;
    logic [3:0]  dstrb;
    logic [31:0] daddr, dwdata, rsp_rdata;

    logic        accept, misal, expire;
    logic [3:0]  strb_in;
    logic [31:0] wdata_in, ld_data;
    logic [7:0]  bsel;
    logic [15:0] hsel;

    assign bus.req_ready = (state == IDLE) && reset;
    assign bus.dvalid    = dvalid;
    assign bus.dwrite    = dwrite;
    assign bus.dstrb     = dstrb;
    assign bus.daddr     = daddr;
    assign bus.dwdata    = dwdata;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_fault = rsp_fault;
    assign bus.rsp_rdata = rsp_rdata;

    always_comb begin
        accept   = bus.req_valid && bus.req_ready;
        misal    = (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                   (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00) ||
                   (bus.req_size == 2'b11);
        // dready in the expiry cycle wins, so expiry is qualified by !dready
        expire   = (state == BUS) && !bus.dready && (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);

        strb_in  = 4'b1111;
        wdata_in = bus.req_wdata;
        case (bus.req_size)
            2'b00: begin
                strb_in  = 4'b0001 << bus.req_addr[1:0];
                wdata_in = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                strb_in  = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_in = {2{bus.req_wdata[15:0]}};
            end
            default: ;
        endcase

        bsel = bus.drdata[{lane_q, 3'b000} +: 8];
        hsel = lane_q[1] ? bus.drdata[31:16] : bus.drdata[15:0];
        case (size_q)
            2'b00:   ld_data = {{24{~uns_q & bsel[7]}}, bsel};
            2'b01:   ld_data = {{16{~uns_q & hsel[15]}}, hsel};
            default: ld_data = bus.drdata;
        endcase

        state_n = state;
        case (state)
            IDLE: if (accept) state_n = misal ? RESP : BUS;
            BUS:  if (bus.dready || expire) state_n = RESP;
            RESP: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            dvalid    <= 1'b0;
            dwrite    <= 1'b0;
            dstrb     <= 4'b0;
            daddr     <= 32'b0;
            dwdata    <= 32'b0;
            rsp_valid <= 1'b0;
            rsp_fault <= 1'b0;
            rsp_rdata <= 32'b0;
            cnt       <= 8'b0;
            lane_q    <= 2'b0;
            size_q    <= 2'b0;
            uns_q     <= 1'b0;
            wr_q      <= 1'b0;
        end else begin
            state     <= state_n;
            rsp_valid <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (misal) begin
                        rsp_valid <= 1'b1;
                        rsp_fault <= 1'b1;
                        rsp_rdata <= 32'b0;
                    end else begin
                        lane_q <= bus.req_addr[1:0];
                        size_q <= bus.req_size;
                        uns_q  <= bus.req_unsigned;
                        wr_q   <= bus.req_write;
                        daddr  <= {bus.req_addr[31:2], 2'b00};
                        dwdata <= wdata_in;
                        dstrb  <= strb_in;
                        dwrite <= bus.req_write;
                        dvalid <= 1'b1;
                        cnt    <= 8'b0;
                    end
                end
                BUS: begin
                    if (bus.dready || expire) begin
                        dvalid    <= 1'b0;
                        dstrb     <= 4'b0;
                        dwrite    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_fault <= !bus.dready;
                        rsp_rdata <= (bus.dready && !wr_q) ? ld_data : 32'b0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fwrisc_lsu.sv
// Self-checking bench for fwrisc_lsu: vector table drives transactions, a
// response queue holds expected results that the response monitor pops.
module tb_fwrisc_lsu;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    fwrisc_lsu_if bus();
    fwrisc_lsu #(.TIMEOUT_CYCLES(4)) dut (.clock(clock), .reset(reset), .bus(bus));

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] drdata;
        int          waits;
        logic        rdy;
        logic        bad;
        logic [3:0]  strb;
        logic [31:0] dwd;
        logic [31:0] rdata;
        logic        fault;
    } vec_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        fault;
    } rsp_t;

    rsp_t sbq[$];
    vec_t vecs[$];
    int   nchk  = 0;
    int   nfail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(string nm, logic [31:0] a, logic w, logic [1:0] sz, logic u,
                                logic [31:0] wd, logic [31:0] dr, int wt, logic rdy, logic bad,
                                logic [3:0] st, logic [31:0] dwd, logic [31:0] rd, logic f);
        vec_t v;
        v.name = nm; v.addr = a; v.wr = w; v.size = sz; v.uns = u; v.wdata = wd;
        v.drdata = dr; v.waits = wt; v.rdy = rdy; v.bad = bad; v.strb = st;
        v.dwd = dwd; v.rdata = rd; v.fault = f;
        return v;
    endfunction

    // Response monitor: every rsp_valid must match the oldest queued expectation.
    always @(negedge clock) begin
        if (bus.rsp_valid) begin
            if (sbq.size() == 0) begin
                nchk++; nfail++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response");
            end else begin
                rsp_t e;
                e = sbq.pop_front();
                chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                chk("rsp_fault", {31'b0, bus.rsp_fault}, {31'b0, e.fault});
            end
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clock);
        chk("req_ready_wait", {31'b0, bus.req_ready}, 32'd1);
    endtask

    task automatic drive_req(input vec_t v);
        bus.req_valid    = 1'b1;
        bus.req_addr     = v.addr;
        bus.req_write    = v.wr;
        bus.req_size     = v.size;
        bus.req_unsigned = v.uns;
        bus.req_wdata    = v.wdata;
    endtask

    // Called on a negedge; returns on the negedge after the response cycle.
    task automatic run(input vec_t v);
        rsp_t e;
        wait_ready();
        drive_req(v);
        @(posedge clock);
        e.rdata = v.rdata;
        e.fault = v.fault;
        sbq.push_back(e);
        #1 bus.req_valid = 1'b0;
        if (v.bad) begin
            @(negedge clock);
            chk({v.name, ":dvalid"}, {31'b0, bus.dvalid}, 32'd0);
            chk({v.name, ":rsp_n1"}, {31'b0, bus.rsp_valid}, 32'd1);
        end else begin
            for (int w = 0; w <= v.waits; w++) begin
                @(negedge clock);
                chk({v.name, ":dvalid"}, {31'b0, bus.dvalid}, 32'd1);
                chk({v.name, ":daddr"}, bus.daddr, {v.addr[31:2], 2'b00});
                chk({v.name, ":dstrb"}, {28'b0, bus.dstrb}, {28'b0, v.strb});
                chk({v.name, ":dwrite"}, {31'b0, bus.dwrite}, {31'b0, v.wr});
                if (v.wr) chk({v.name, ":dwdata"}, bus.dwdata, v.dwd);
                chk({v.name, ":ready_busy"}, {30'b0, bus.req_ready, bus.rsp_valid}, 32'd0);
                bus.dready = (w == v.waits) && v.rdy;
                bus.drdata = bus.dready ? v.drdata : $urandom;
                @(posedge clock);
                #1 bus.dready = 1'b0;
            end
            @(negedge clock);
            chk({v.name, ":rsp"}, {30'b0, bus.dvalid, bus.rsp_valid}, 32'd1);
            chk({v.name, ":dstrb_clr"}, {28'b0, bus.dstrb}, 32'd0);
        end
        @(negedge clock);
        chk({v.name, ":rsp_pulse"}, {31'b0, bus.rsp_valid}, 32'd0);
        chk({v.name, ":rdata_hold"}, bus.rsp_rdata, v.rdata);
    endtask

    initial begin
        vec_t rv;
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_write = 1'b0; bus.req_size = '0;
        bus.req_unsigned = 1'b0; bus.req_wdata = '0; bus.dready = 1'b0; bus.drdata = '0;

        //        name         addr        wr    size   uns   wdata          drdata         wt rdy  bad  strb   dwdata         rdata          fault
        vecs.push_back(mk("lw_0x100",  32'h100, 1'b0, 2'b10, 1'b0, 32'hDEADBEEF, 32'h87654321, 0, 1'b1, 1'b0, 4'hF, 32'h0,        32'h87654321, 1'b0));
        vecs.push_back(mk("lb_0x203",  32'h203, 1'b0, 2'b00, 1'b0, 32'h0,        32'h80123456, 0, 1'b1, 1'b0, 4'h8, 32'h0,        32'hFFFFFF80, 1'b0));
        vecs.push_back(mk("lbu_0x203", 32'h203, 1'b0, 2'b00, 1'b1, 32'h0,        32'h80123456, 0, 1'b1, 1'b0, 4'h8, 32'h0,        32'h00000080, 1'b0));
        vecs.push_back(mk("sh_0x302",  32'h302, 1'b1, 2'b01, 1'b0, 32'h1234ABCD, 32'h0,        3, 1'b1, 1'b0, 4'hC, 32'hABCDABCD, 32'h0,        1'b0));
        vecs.push_back(mk("lw_mis",    32'h102, 1'b0, 2'b10, 1'b0, 32'h0,        32'h0,        0, 1'b0, 1'b1, 4'h0, 32'h0,        32'h0,        1'b1));
        vecs.push_back(mk("size11",    32'h000, 1'b0, 2'b11, 1'b0, 32'h0,        32'h0,        0, 1'b0, 1'b1, 4'h0, 32'h0,        32'h0,        1'b1));
        vecs.push_back(mk("timeout",   32'h400, 1'b0, 2'b10, 1'b0, 32'h0,        32'h0,        3, 1'b0, 1'b0, 4'hF, 32'h0,        32'h0,        1'b1));
        vecs.push_back(mk("expiry_rdy",32'h404, 1'b0, 2'b10, 1'b0, 32'h0,        32'h11223344, 3, 1'b1, 1'b0, 4'hF, 32'h0,        32'h11223344, 1'b0));
        vecs.push_back(mk("lh_hi",     32'h002, 1'b0, 2'b01, 1'b0, 32'h0,        32'h80017FFF, 0, 1'b1, 1'b0, 4'hC, 32'h0,        32'hFFFF8001, 1'b0));
        vecs.push_back(mk("lhu_lo",    32'h000, 1'b0, 2'b01, 1'b1, 32'h0,        32'h8001F00F, 1, 1'b1, 1'b0, 4'h3, 32'h0,        32'h0000F00F, 1'b0));
        vecs.push_back(mk("lb_lane1",  32'h001, 1'b0, 2'b00, 1'b0, 32'h0,        32'h00007F00, 0, 1'b1, 1'b0, 4'h2, 32'h0,        32'h0000007F, 1'b0));
        vecs.push_back(mk("lh_mis",    32'h105, 1'b0, 2'b01, 1'b0, 32'h0,        32'h0,        0, 1'b0, 1'b1, 4'h0, 32'h0,        32'h0,        1'b1));
        vecs.push_back(mk("sw_0x10",   32'h010, 1'b1, 2'b10, 1'b0, 32'hCAFEF00D, 32'h0,        1, 1'b1, 1'b0, 4'hF, 32'hCAFEF00D, 32'h0,        1'b0));
        vecs.push_back(mk("sb_0x002",  32'h002, 1'b1, 2'b00, 1'b0, 32'h000000A5, 32'h0,        0, 1'b1, 1'b0, 4'h4, 32'hA5A5A5A5, 32'h0,        1'b0));

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_ctl", {27'b0, bus.dvalid, bus.dwrite, bus.rsp_valid, bus.rsp_fault, bus.req_ready}, 32'd0);
        chk("reset_dstrb", {28'b0, bus.dstrb}, 32'd0);
        chk("reset_daddr", bus.daddr, 32'd0);
        chk("reset_dwdata", bus.dwdata, 32'd0);
        chk("reset_rdata", bus.rsp_rdata, 32'd0);
        reset = 1'b1;
        @(negedge clock);

        foreach (vecs[i]) run(vecs[i]);

        // Reset while a load is waiting on the bus: transaction dropped, no response.
        rv = mk("rst_mid", 32'h500, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 0, 1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0);
        wait_ready();
        drive_req(rv);
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        @(negedge clock);
        chk("rst_mid:dvalid_on", {31'b0, bus.dvalid}, 32'd1);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("rst_mid:dvalid_off", {30'b0, bus.dvalid, bus.rsp_valid}, 32'd0);
        chk("rst_mid:ready_low", {31'b0, bus.req_ready}, 32'd0);
        reset = 1'b1;
        #1 chk("rst_mid:ready_high", {31'b0, bus.req_ready}, 32'd1);
        run(mk("sb_0x001", 32'h001, 1'b1, 2'b00, 1'b0, 32'h0000005A, 32'h0, 0, 1'b1, 1'b0, 4'h2, 32'h5A5A5A5A, 32'h0, 1'b0));

        repeat (2) @(negedge clock);
        chk("queue_empty", sbq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end
endmodule
